// File: rtl/iscas_ctrl_gen_if.sv
// Bundle for iscas_ctrl_gen: burst control, load data, scan pins and the status outputs.
// Handshake: start has no acknowledge; it is taken only on an edge where busy is low, and the burst result is qualified by the one-cycle done pulse.
interface iscas_ctrl_gen_if #(
  parameter int W     = 8,
  parameter int LEN_W = 4
);
  logic             clr;
  logic             start;
  logic [1:0]       mode;
  logic [LEN_W-1:0] len;
  logic [W-1:0]     din;
  logic             se;
  logic             si;
  logic [W-1:0]     q;
  logic             zero;
  logic             busy;
  logic             done;
  logic             so;
  logic [1:0]       state_dbg;

  modport master (
    output clr, start, mode, len, din, se, si,
    input  q, zero, busy, done, so, state_dbg
  );

  modport slave (
    input  clr, start, mode, len, din, se, si,
    output q, zero, busy, done, so, state_dbg
  );
endinterface

// File: rtl/iscas_ctrl_gen.sv
// W-bit datapath register (hold/count/load/LFSR) driven by a START/LEN burst FSM.
// Define SCAN_CHAIN_EN to build the full scan chain over every flop; otherwise se/si are ignored and so is 0.
module iscas_ctrl_gen #(
  parameter int           W     = 8,
  parameter int           LEN_W = 4,
  parameter logic [W-1:0] TAPS  = 8'hB8
) (
  input logic             clk,
  input logic             rst_n,
  iscas_ctrl_gen_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10,
    ST_ILL  = 2'b11
  } state_t;

  localparam int CHAIN_W = W + LEN_W + 4;

  state_t             st, st_nxt;
  logic [W-1:0]       q, q_nxt, op_q;
  logic [LEN_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         mode_r, mode_nxt;
  logic               scan_shift;
  logic [CHAIN_W-1:0] chain, chain_shifted;

  // Datapath result of one operation in the latched mode; all-zero LFSR escapes to 1.
  always_comb begin
    op_q = q;
    case (mode_r)
      2'b01:   op_q = q + W'(1);
      2'b10:   op_q = bus.din;
      2'b11:   op_q = (q == '0) ? W'(1) : ((q >> 1) ^ (q[0] ? TAPS : '0));
      default: op_q = q;
    endcase
  end

  always_comb begin
    st_nxt   = st;
    q_nxt    = q;
    cnt_nxt  = cnt;
    mode_nxt = mode_r;
    case (st)
      ST_IDLE: begin
        if (bus.start) begin
          mode_nxt = bus.mode;
          if (bus.len != '0) begin
            cnt_nxt = bus.len;
            st_nxt  = ST_RUN;
          end else begin
            st_nxt = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        q_nxt   = op_q;
        cnt_nxt = cnt - LEN_W'(1);
        st_nxt  = (cnt == LEN_W'(1)) ? ST_DONE : ST_RUN;
      end
      default: st_nxt = ST_IDLE;  // DONE, and the scan-only illegal code
    endcase
  end

  // Chain order from si: q msb..lsb, cnt msb..lsb, st, mode_r; so taps mode_r[0].
  assign chain         = {q, cnt, st, mode_r};
  assign chain_shifted = {bus.si, chain[CHAIN_W-1:1]};

`ifdef SCAN_CHAIN_EN
  assign scan_shift = bus.se;
  assign bus.so     = mode_r[0];
`else
  logic unused_scan;
  assign scan_shift  = 1'b0;
  assign bus.so      = 1'b0;
  assign unused_scan = &{1'b0, bus.se};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      cnt    <= '0;
      st     <= ST_IDLE;
      mode_r <= '0;
    end else if (scan_shift) begin
      q      <= chain_shifted[CHAIN_W-1 -: W];
      cnt    <= chain_shifted[LEN_W+3 -: LEN_W];
      st     <= state_t'(chain_shifted[3:2]);
      mode_r <= chain_shifted[1:0];
    end else if (bus.clr) begin
      q      <= '0;
      cnt    <= '0;
      st     <= ST_IDLE;
      mode_r <= '0;
    end else begin
      q      <= q_nxt;
      cnt    <= cnt_nxt;
      st     <= st_nxt;
      mode_r <= mode_nxt;
    end
  end

  assign bus.q         = q;
  assign bus.zero      = (q == '0);
  assign bus.busy      = (st != ST_IDLE);
  assign bus.done      = (st == ST_DONE);
  assign bus.state_dbg = st;

endmodule

// File: tb/tb_iscas_ctrl_gen.sv
// Bench for iscas_ctrl_gen: directed scenarios plus random bursts against a schedule-queue reference model.
`timescale 1ns/1ps
module tb_iscas_ctrl_gen;
  localparam int           W     = 8;
  localparam int           LEN_W = 4;
  localparam logic [W-1:0] TAPS  = 8'hB8;
  localparam int           OP    = 1;
  localparam int           DN    = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iscas_ctrl_gen_if #(.W(W), .LEN_W(LEN_W)) bus ();

  iscas_ctrl_gen #(.W(W), .LEN_W(LEN_W), .TAPS(TAPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: q expected at each done pulse
  logic [W-1:0] exp_q[$];

  // reference model: pending edges of the current burst (OP = one operation, DN = done cycle)
  logic [W-1:0] m_q;
  logic [1:0]   m_mode;
  int           sched[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] apply_op(input logic [1:0] md, input logic [W-1:0] qv,
                                            input logic [W-1:0] d);
    int v;
    v = int'(qv);
    case (md)
      2'd1:    v = (v + 1) % (1 << W);
      2'd2:    v = int'(d);
      2'd3:    v = (v == 0) ? 1 : ((v / 2) ^ ((v % 2 == 1) ? int'(TAPS) : 0));
      default: ;
    endcase
    return W'(v);
  endfunction

  task automatic model_edge();
    if (bus.clr) begin
      sched.delete();
      m_q    = '0;
      m_mode = '0;
    end else if (sched.size() == 0) begin
      if (bus.start) begin
        m_mode = bus.mode;
        repeat (int'(bus.len)) sched.push_back(OP);
        sched.push_back(DN);
        if (bus.len == '0) exp_q.push_back(m_q);
      end
    end else if (sched.pop_front() == OP) begin
      m_q = apply_op(m_mode, m_q, bus.din);
      if (sched.size() == 1) exp_q.push_back(m_q);
    end
  endtask

  task automatic compare_outputs();
    check("q", bus.q, m_q);
    check("zero", bus.zero, m_q == '0);
    check("busy", bus.busy, sched.size() != 0);
    check("done", bus.done, sched.size() == 1);
    if (bus.done) begin
      if (exp_q.size() != 0) check("done_q", bus.q, exp_q.pop_front());
      else check("spurious_done", bus.done, 1'b0);
    end
  endtask

  // driver: inputs are set at negedge, model advances, outputs compared at the next negedge
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic start_burst(input logic [1:0] md, input logic [LEN_W-1:0] ln, input logic [W-1:0] d);
    bus.start = 1'b1;
    bus.mode  = md;
    bus.len   = ln;
    bus.din   = d;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 40 && sched.size() != 0; i++) step();
    check("idle_reached", bus.busy, 1'b0);
  endtask

  initial begin
    int dones;
    logic [15:0] img;
    bus.clr   = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    bus.len   = '0;
    bus.din   = '0;
    bus.se    = 1'b0;
    bus.si    = 1'b0;
    m_q       = '0;
    m_mode    = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_q", bus.q, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_zero", bus.zero, 1'b1);
    check("rst_state", bus.state_dbg, 2'b00);
    rst_n = 1'b1;
    step();

    // async reset two cycles into a LEN=5 count burst
    start_burst(2'b01, 4'd5, 8'h00);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", bus.q, 8'h00);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    sched.delete();
    m_q    = '0;
    m_mode = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step();

    // count wrap
    start_burst(2'b10, 4'd1, 8'hFE);
    run_to_idle();
    check("load_fe", bus.q, 8'hFE);
    start_burst(2'b01, 4'd3, 8'h00);
    step();
    check("wrap_ff", bus.q, 8'hFF);
    check("wrap_ff_zero", bus.zero, 1'b0);
    step();
    check("wrap_00", bus.q, 8'h00);
    check("wrap_00_zero", bus.zero, 1'b1);
    check("wrap_00_done", bus.done, 1'b0);
    step();
    check("wrap_01", bus.q, 8'h01);
    check("wrap_done", bus.done, 1'b1);
    step();
    check("wrap_done_end", bus.done, 1'b0);
    check("wrap_idle", bus.busy, 1'b0);

    // LFSR from zero
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    check("clr_q", bus.q, 8'h00);
    start_burst(2'b11, 4'd3, 8'h00);
    step();
    check("lfsr_escape", bus.q, 8'h01);
    step();
    check("lfsr_b8", bus.q, 8'hB8);
    step();
    check("lfsr_5c", bus.q, 8'h5C);
    run_to_idle();

    // LEN=0 burst
    start_burst(2'b01, 4'd0, 8'h00);
    check("len0_done", bus.done, 1'b1);
    check("len0_q", bus.q, 8'h5C);
    step();
    check("len0_idle", bus.busy, 1'b0);

    // start while busy is ignored
    start_burst(2'b00, 4'd4, 8'h00);
    step();
    bus.start = 1'b1;
    bus.len   = 4'd2;
    step();
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done) dones++;
    end
    check("one_done", dones, 1);

    // CLR abort at the 2nd RUN edge of a LEN=6 count burst
    start_burst(2'b10, 4'd1, 8'h10);
    run_to_idle();
    start_burst(2'b01, 4'd6, 8'h00);
    step();
    check("abort_run1", bus.q, 8'h11);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    check("abort_q", bus.q, 8'h00);
    check("abort_state", bus.state_dbg, 2'b00);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);

`ifdef SCAN_CHAIN_EN
    // scan: preload A5, clear mode_r with a LEN=0 hold burst, then shift ones through
    start_burst(2'b10, 4'd1, 8'hA5);
    run_to_idle();
    start_burst(2'b00, 4'd0, 8'h00);
    run_to_idle();
    img = {8'hA5, 4'h0, 2'b00, 2'b00};
    bus.se = 1'b1;
    bus.si = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("scan_so", bus.so, img[k]);
      @(posedge clk);
      @(negedge clk);
    end
    check("scan_q", bus.q, 8'hFF);
    check("scan_state", bus.state_dbg, 2'b11);
    check("scan_busy", bus.busy, 1'b1);
    bus.se = 1'b0;
    bus.si = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("scan_recover_state", bus.state_dbg, 2'b00);
    check("scan_recover_q", bus.q, 8'hFF);
    sched.delete();
    m_q = 8'hFF;
`else
    img = '0;
    bus.se = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.si = 1'($urandom_range(0, 1));
      step();
      check("so_off", bus.so, img[k]);
    end
    bus.se = 1'b0;
    bus.si = 1'b0;
`endif

    // random traffic against the model
    repeat (400) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.mode  = 2'($urandom_range(0, 3));
      bus.len   = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(7, 15)) : LEN_W'($urandom_range(0, 5));
      bus.din   = W'($urandom);
      bus.clr   = ($urandom_range(0, 39) == 0);
      step();
    end
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    run_to_idle();
    check("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
